// File: rtl/mult_share_scheduler.sv
// Round-robin scheduler that time-shares one external N x N multiplier among NREQ requesters.
// One operation is in flight at a time: grant in IDLE, wait out the multiplier latency, hold the result.
module mult_share_scheduler #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic [2*N-1:0]      mul_p,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*N-1:0]      rsp_product,
  input  logic                rsp_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [3:0]     count;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_found;
  logic           accept;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;

  // Search begins one past the last winner so every requester is served in turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(last_grant) + 1 + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

  // The grant is only offered out of reset and in IDLE, so req_ready is zero while rst_n is low.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && grant_found) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_next           = WAIT;
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Counter runs LAT down to 0 over the latency window; the edge after it reaches 0 captures mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 4'd0;
      last_grant  <= IDW'(NREQ - 1);
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a      <= sel_a;
            mul_b      <= sel_b;
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
            count      <= 4'(LAT);
          end
        end
        WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            rsp_product <= mul_p;
            rsp_valid   <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Directed bench for mult_share_scheduler: a LAT=1 instance driven through a response scoreboard
// and a LAT=3 instance for latency timing; each has a behavioural pipelined multiplier.
module tb_mult_share_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rel_cyc = 0;

  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_product;

  logic [3:0]  d3_req_valid, d3_req_ready;
  logic [63:0] d3_req_a, d3_req_b;
  logic [15:0] d3_mul_a, d3_mul_b;
  logic [31:0] d3_mul_p;
  logic        d3_rsp_valid, d3_rsp_ready, d3_busy;
  logic [1:0]  d3_rsp_id;
  logic [31:0] d3_rsp_product;
  logic [31:0] d3_pipe [3];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] prod;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          acc_cyc[$];
  logic [3:0]  acc_grant[$];

  mult_share_scheduler #(.N(16), .NREQ(4), .LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  mult_share_scheduler #(.N(16), .NREQ(4), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(d3_req_valid), .req_a(d3_req_a), .req_b(d3_req_b),
    .req_ready(d3_req_ready), .mul_a(d3_mul_a), .mul_b(d3_mul_b), .mul_p(d3_mul_p),
    .rsp_valid(d3_rsp_valid), .rsp_id(d3_rsp_id), .rsp_product(d3_rsp_product),
    .rsp_ready(d3_rsp_ready), .busy(d3_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared multipliers: LAT register stages from operands to product.
  always @(posedge clk) mul_p <= 32'(mul_a) * 32'(mul_b);

  always @(posedge clk) begin
    d3_pipe[0] <= 32'(d3_mul_a) * 32'(d3_mul_b);
    d3_pipe[1] <= d3_pipe[0];
    d3_pipe[2] <= d3_pipe[1];
  end
  assign d3_mul_p = d3_pipe[2];

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // A request seen at the falling edge is accepted on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && ((req_valid & req_ready) != 4'b0)) begin
      acc_cyc.push_back(cyc);
      acc_grant.push_back(req_valid & req_ready);
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      check_output("rsp_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output("rsp_id", 64'(rsp_id), 64'(e.id));
        check_output("rsp_product", 64'(rsp_product), 64'(e.prod));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[idx*16 +: 16] = a;
    req_b[idx*16 +: 16] = b;
    req_valid[idx]      = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b);
    exp_t x;
    x.id   = id;
    x.prod = 32'(a) * 32'(b);
    sb.push_back(x);
  endtask

  task automatic enter_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    acc_cyc.delete();
    acc_grant.delete();
  endtask

  task automatic release_reset();
    tick();
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n = 0;
    while (acc_cyc.size() < target && n < budget) begin
      tick();
      n++;
    end
    check_output("accept_seen", 64'(acc_cyc.size() >= target), 64'd1);
  endtask

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_output("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_grants(input int first, input logic [3:0] exp_grant [5], input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (acc_grant.size() > first + k)
        check_output("grant_order", 64'(acc_grant[first+k]), 64'(exp_grant[k]));
      else
        check_output("grant_missing", 64'(acc_grant.size()), 64'(first + k + 1));
    end
  endtask

  initial begin
    int edges;
    int n;
    logic [3:0] g_alt [5];
    logic [3:0] g_all [5];
    g_alt = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000};
    g_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    d3_req_valid = '0; d3_req_a = '0; d3_req_b = '0; d3_rsp_ready = 1'b0;

    $display("[TB] reset values");
    req_valid = 4'b0001;
    tick(); tick();
    check_output("rst_req_ready", 64'(req_ready), 64'd0);
    check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_mul_a", 64'(mul_a), 64'd0);
    check_output("rst_mul_b", 64'(mul_b), 64'd0);
    check_output("rst_rsp_product", 64'(rsp_product), 64'd0);
    check_output("rst_rsp_id", 64'(rsp_id), 64'd0);
    req_valid = '0;
    release_reset();

    $display("[TB] single max-operand request from requester 2");
    tick();
    rsp_ready = 1'b1;
    apply_stimulus(2, 16'hFFFF, 16'hFFFF);
    push_exp(2, 16'hFFFF, 16'hFFFF);
    #1;
    check_output("single_req_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    check_output("single_busy", 64'(busy), 64'd1);
    check_output("single_mul_a", 64'(mul_a), 64'hFFFF);
    check_output("single_mul_b", 64'(mul_b), 64'hFFFF);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!rsp_valid && edges < 10);
    check_output("lat1_rsp_edges", 64'(edges), 64'd2);
    check_output("lat1_product", 64'(rsp_product), 64'hFFFE0001);
    wait_sb_empty(20);

    $display("[TB] two requesters held valid from reset");
    enter_reset();
    apply_stimulus(0, 16'h0102, 16'h0304);
    apply_stimulus(1, 16'h1111, 16'h000F);
    push_exp(0, 16'h0102, 16'h0304);
    push_exp(1, 16'h1111, 16'h000F);
    push_exp(0, 16'h0102, 16'h0304);
    push_exp(1, 16'h1111, 16'h000F);
    rsp_ready = 1'b1;
    release_reset();
    wait_accepts(4, 40);
    tick();
    req_valid = '0;
    wait_sb_empty(30);
    check_grants(0, g_alt, 4);
    if (acc_cyc.size() >= 4) begin
      check_output("first_accept_edge", 64'(acc_cyc[0]), 64'(rel_cyc));
      for (int k = 1; k < 4; k++)
        check_output("accept_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd4);
    end

    $display("[TB] response stall with a pending requester");
    rsp_ready = 1'b0;
    apply_stimulus(3, 16'h1234, 16'h0010);
    push_exp(3, 16'h1234, 16'h0010);
    wait_accepts(5, 20);
    tick();
    req_valid = '0;
    apply_stimulus(0, 16'h00AA, 16'h0055);
    push_exp(0, 16'h00AA, 16'h0055);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check_output("stall_rsp_seen", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check_output("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check_output("stall_rsp_id", 64'(rsp_id), 64'd3);
      check_output("stall_rsp_product", 64'(rsp_product), 64'h00012340);
      check_output("stall_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    wait_accepts(6, 20);
    tick();
    req_valid = '0;
    wait_sb_empty(20);
    check_grants(5, g_all, 1);

    $display("[TB] reset during WAIT");
    apply_stimulus(1, 16'h0007, 16'h0009);
    wait_accepts(7, 20);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_output("wait_rst_busy", 64'(busy), 64'd0);
    check_output("wait_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("wait_rst_mul_a", 64'(mul_a), 64'd0);
    check_output("wait_rst_mul_b", 64'(mul_b), 64'd0);
    check_output("wait_rst_rsp_product", 64'(rsp_product), 64'd0);
    check_output("wait_rst_rsp_id", 64'(rsp_id), 64'd0);
    check_output("wait_rst_req_ready", 64'(req_ready), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_output("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      check_output("post_rst_idle", 64'(busy), 64'd0);
    end

    $display("[TB] all four requesters, wrap-around");
    enter_reset();
    apply_stimulus(0, 16'h0011, 16'h0022);
    apply_stimulus(1, 16'h0100, 16'h0100);
    apply_stimulus(2, 16'hABCD, 16'h0002);
    apply_stimulus(3, 16'h8000, 16'h8000);
    push_exp(0, 16'h0011, 16'h0022);
    push_exp(1, 16'h0100, 16'h0100);
    push_exp(2, 16'hABCD, 16'h0002);
    push_exp(3, 16'h8000, 16'h8000);
    push_exp(0, 16'h0011, 16'h0022);
    release_reset();
    wait_accepts(5, 60);
    tick();
    req_valid = '0;
    wait_sb_empty(30);
    check_grants(0, g_all, 5);

    $display("[TB] LAT=3 instance timing");
    tick();
    d3_rsp_ready = 1'b1;
    d3_req_a[15:0] = 16'h0003;
    d3_req_b[15:0] = 16'h0005;
    d3_req_valid   = 4'b0001;
    #1;
    check_output("lat3_req_ready", 64'(d3_req_ready), 64'b0001);
    tick();
    d3_req_valid = '0;
    edges = 0;
    do begin
      check_output("lat3_mul_a", 64'(d3_mul_a), 64'h3);
      check_output("lat3_mul_b", 64'(d3_mul_b), 64'h5);
      tick();
      edges++;
    end while (!d3_rsp_valid && edges < 12);
    check_output("lat3_rsp_edges", 64'(edges), 64'd4);
    check_output("lat3_product", 64'(d3_rsp_product), 64'h0000000F);
    check_output("lat3_rsp_id", 64'(d3_rsp_id), 64'd0);
    tick();
    check_output("lat3_idle", 64'(d3_busy), 64'd0);
    check_output("lat3_rsp_cleared", 64'(d3_rsp_valid), 64'd0);

    tick();
    check_output("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
